// File: rtl/mdu_sequencer_if.sv
// Bus between the EX stage and the multiply/divide sequencer.
// start/operands come from EX, and stall/done/result go back to it.
interface mdu_sequencer_if;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] data1;
   logic [31:0] data2;
   logic        flush;
   logic        stall;
   logic        done;
   logic [31:0] result;

   modport master (output start, funct3, data1, data2, flush,
                   input  stall, done, result);
   modport slave  (input  start, funct3, data1, data2, flush,
                   output stall, done, result);
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative RV32M unit: radix-2 shift-add multiply and restoring divide.
// Ops run for 32 CALC cycles; divide-by-zero and signed overflow finish at once.
module mdu_sequencer (
   input  logic                 clk,
   input  logic                 reset,
   mdu_sequencer_if.slave       bus,
   output logic [1:0]           state_dbg
);
   // Handshake: EX holds start with its operands; stall=1 means the op is not
   // yet finished, and done pulses for one cycle with result valid and stall=0.
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state, state_nx;
   logic [2:0]  op;
   logic [5:0]  cnt;
   logic [31:0] mcand;
   logic [63:0] acc;
   logic [31:0] rem;
   logic        neg_q, neg_r;
   logic [31:0] result_q;

   logic        accept, op_signed_a, op_signed_b, sgn_a, sgn_b;
   logic [31:0] mag_a, mag_b;
   logic        div_zero, div_ovf, special;
   logic [31:0] special_res;

   assign accept      = (state == IDLE) && bus.start && !bus.flush;
   assign op_signed_a = bus.funct3 inside {3'b001, 3'b010, 3'b100, 3'b110};
   assign op_signed_b = bus.funct3 inside {3'b001, 3'b100, 3'b110};
   assign sgn_a       = op_signed_a & bus.data1[31];
   assign sgn_b       = op_signed_b & bus.data2[31];
   assign mag_a       = sgn_a ? (32'd0 - bus.data1) : bus.data1;
   assign mag_b       = sgn_b ? (32'd0 - bus.data2) : bus.data2;
   assign div_zero    = bus.funct3[2] && (bus.data2 == 32'd0);
   assign div_ovf     = bus.funct3[2] && !bus.funct3[0] &&
                        (bus.data1 == 32'h8000_0000) && (bus.data2 == 32'hFFFF_FFFF);
   assign special     = div_zero || div_ovf;
   assign special_res = div_zero ? (bus.funct3[1] ? bus.data1 : 32'hFFFF_FFFF)
                                 : (bus.funct3[1] ? 32'd0 : 32'h8000_0000);

   // One iteration step of each algorithm; acc[31:0] holds multiplier or dividend/quotient.
   logic [32:0] mul_sum, div_shift, div_trial;
   logic [63:0] mul_nx, div_nx, prod;
   logic [31:0] rem_nx, quo_f, rem_f, final_res;
   logic        div_qbit;

   assign mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mcand} : 33'd0);
   assign mul_nx    = {mul_sum, acc[31:1]};
   assign div_shift = {rem, acc[31]};
   assign div_trial = div_shift - {1'b0, mcand};
   assign div_qbit  = ~div_trial[32];
   assign rem_nx    = div_qbit ? div_trial[31:0] : div_shift[31:0];
   assign div_nx    = {32'd0, acc[30:0], div_qbit};
   assign prod      = neg_q ? (64'd0 - mul_nx) : mul_nx;
   assign quo_f     = neg_q ? (32'd0 - div_nx[31:0]) : div_nx[31:0];
   assign rem_f     = neg_r ? (32'd0 - rem_nx) : rem_nx;
   assign final_res = op[2] ? (op[1] ? rem_f : quo_f)
                            : ((op == 3'b000) ? prod[31:0] : prod[63:32]);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = special ? DONE : CALC;
         CALC:    if (cnt == 6'd31) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (bus.flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         op       <= 3'd0;
         cnt      <= 6'd0;
         mcand    <= 32'd0;
         acc      <= 64'd0;
         rem      <= 32'd0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         result_q <= 32'd0;
      end else if (bus.flush) begin
         cnt <= 6'd0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               op    <= bus.funct3;
               cnt   <= 6'd0;
               neg_q <= sgn_a ^ sgn_b;
               neg_r <= sgn_a;
               mcand <= bus.funct3[2] ? mag_b : mag_a;
               acc   <= {32'd0, bus.funct3[2] ? mag_a : mag_b};
               rem   <= 32'd0;
               if (special) result_q <= special_res;
            end
            CALC: begin
               cnt <= cnt + 6'd1;
               acc <= op[2] ? div_nx : mul_nx;
               if (op[2]) rem <= rem_nx;
               if (cnt == 6'd31) result_q <= final_res;
            end
            default: ;
         endcase
      end
   end

   assign bus.stall  = accept || (state == CALC);
   assign bus.done   = (state == DONE);
   assign bus.result = result_q;
   assign state_dbg  = state;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Bench for mdu_sequencer: directed vector table, flush/reset sequences,
// and random ops scored against an arithmetic reference model.
module tb_mdu_sequencer;
   logic       clk;
   logic       reset;
   logic [1:0] state_dbg;
   int         n_tests = 0;
   int         n_fail  = 0;
   logic [31:0] exp_q[$];

   mdu_sequencer_if bus ();

   mdu_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_res;
      int          exp_lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit and signed 32-bit arithmetic.
   function automatic logic [31:0] ref_model(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (f3)
         3'b000: begin p = ua * ub; return p[31:0]; end
         3'b001: begin p = sa * sb; return p[63:32]; end
         3'b010: begin p = sa * ub; return p[63:32]; end
         3'b011: begin p = ua * ub; return p[63:32]; end
         3'b100: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'b110: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
            return $signed(a) % $signed(b);
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic logic [31:0] exp_lat(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
      if (f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
         return 32'd1;
      return 32'd33;
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   // Presents one op in IDLE and measures cycles to done; operands are scrambled
   // after acceptance, and start is optionally held high during CALC.
   task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input bit hold, output logic [31:0] res, output int lat,
                        output bit stall_ok);
      res = '0;
      lat = -1;
      stall_ok = 1'b1;
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = f3; bus.data1 = a; bus.data2 = b; bus.flush = 1'b0;
      #1;
      if (bus.stall !== 1'b1 || bus.done !== 1'b0) stall_ok = 1'b0;
      for (int k = 1; k <= 80; k++) begin
         @(posedge clk);
         #1;
         bus.start = hold; bus.funct3 = 3'($urandom);
         bus.data1 = $urandom; bus.data2 = $urandom;
         @(negedge clk);
         if (bus.done === 1'b1) begin
            bus.start = 1'b0;
            if (bus.stall !== 1'b0) stall_ok = 1'b0;
            res = bus.result;
            lat = k;
            break;
         end
         if (bus.stall !== 1'b1) stall_ok = 1'b0;
      end
      bus.start = 1'b0;
   endtask

   initial begin
      vec_t        vecs[14];
      logic [31:0] res, r0;
      int          lat;
      bit          sok, seen;
      logic [2:0]  f3;
      logic [31:0] a, b;

      vecs[0]  = '{3'b000, 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFF9, 33};
      vecs[1]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
      vecs[2]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};
      vecs[3]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
      vecs[4]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};
      vecs[5]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};
      vecs[6]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};
      vecs[7]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};
      vecs[8]  = '{3'b101, 32'hDEAD_BEEF, 32'h0000_0000, 32'hFFFF_FFFF, 1};
      vecs[9]  = '{3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 1};
      vecs[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
      vecs[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1};
      vecs[12] = '{3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33};
      vecs[13] = '{3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33};

      // Reset state
      reset = 1'b0;
      bus.start = 1'b0; bus.funct3 = 3'd0; bus.data1 = '0; bus.data2 = '0; bus.flush = 1'b0;
      #12;
      check("reset_stall",  {31'd0, bus.stall}, 32'd0);
      check("reset_done",   {31'd0, bus.done},  32'd0);
      check("reset_result", bus.result,         32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Directed vectors
      for (int i = 0; i < 14; i++) begin
         do_op(vecs[i].f3, vecs[i].a, vecs[i].b, bit'(i % 2), res, lat, sok);
         check($sformatf("vec%0d_res", i), res, vecs[i].exp_res);
         check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
         check($sformatf("vec%0d_stall", i), {31'd0, sok}, 32'd1);
      end

      // Flush at cycle 10 of a DIV
      r0 = bus.result;
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'b100; bus.data1 = 32'hFFFF_FFF9; bus.data2 = 32'd2;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (9) @(posedge clk);
      @(negedge clk);
      bus.flush = 1'b1;
      @(posedge clk);
      #1 bus.flush = 1'b0;
      @(negedge clk);
      check("flush_idle_stall", {31'd0, bus.stall}, 32'd0);
      check("flush_idle_state", {30'd0, state_dbg}, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check("flush_no_done", {31'd0, seen}, 32'd0);
      check("flush_result_kept", bus.result, r0);

      // Flush has priority over start in IDLE
      bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b000;
      #1 check("flush_prio_stall", {31'd0, bus.stall}, 32'd0);
      @(posedge clk);
      #1 begin bus.start = 1'b0; bus.flush = 1'b0; end
      @(negedge clk);
      check("flush_prio_not_calc", {31'd0, bus.stall}, 32'd0);

      do_op(3'b000, 32'd3, 32'd5, 1'b0, res, lat, sok);
      check("post_flush_mul_res", res, 32'd15);
      check("post_flush_mul_lat", 32'(lat), 32'd33);

      // Reset at cycle 20 of a MULHU with start held through CALC
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'b011; bus.data1 = 32'hFFFF_FFFF; bus.data2 = 32'hFFFF_FFFF;
      repeat (19) @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midreset_stall",  {31'd0, bus.stall}, 32'd0);
      check("midreset_done",   {31'd0, bus.done},  32'd0);
      check("midreset_result", bus.result,         32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done === 1'b1) seen = 1'b1;
      end
      check("midreset_no_done", {31'd0, seen}, 32'd0);

      // Random ops against the reference model
      for (int i = 0; i < 200; i++) begin
         f3 = 3'($urandom_range(0, 7));
         a  = pick();
         b  = pick();
         exp_q.push_back(ref_model(f3, a, b));
         do_op(f3, a, b, bit'(i % 2), res, lat, sok);
         check($sformatf("rand%0d_res_f%0d", i, f3), res, exp_q.pop_front());
         check($sformatf("rand%0d_lat", i), 32'(lat), exp_lat(f3, a, b));
         check($sformatf("rand%0d_stall", i), {31'd0, sok}, 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset; these are fixed.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous reset, active-low.
REQ-004 start  input  1  EX stage holds an M-extension op this cycle.
REQ-005 funct3  input  3  op code: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 data1  input  32  operand A (rs1).
REQ-007 data2  input  32  operand B (rs2).
REQ-008 flush  input  1  synchronous abort from branch/jump resolution.
REQ-009 stall  output  1  freeze PC, IF/ID and ID/EX registers.
REQ-010 done  output  1  one-cycle pulse; result is valid.
REQ-011 result  output  32  M-extension result.

Function
REQ-012 The FSM SHALL use the states IDLE, CALC and DONE.
REQ-013 In IDLE with start=1 and flush=0, the rising edge SHALL latch funct3 and the operands, and SHALL clear the 6-bit counter.
REQ-014 On that edge, the FSM SHALL enter CALC, except for a divide special case, where it SHALL go directly to DONE.
REQ-015 Signed ops SHALL iterate on magnitudes and apply the sign at the DONE transition:
  - MULH: both operands signed.
  - MULHSU: data1 signed, data2 unsigned.
  - DIV/REM: both operands signed.
REQ-016 Multiply SHALL use radix-2 shift-add.
  - One partial-product step per CALC cycle.
  - 64-bit accumulator.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
REQ-017 Divide SHALL use radix-2 restoring division.
  - One quotient bit per CALC cycle, MSB first.
  - 33-bit partial remainder.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
REQ-018 CALC SHALL last exactly 32 cycles (counter 0..31), then move to DONE.
REQ-019 DONE SHALL last one cycle with done=1 and result valid, then return to IDLE.
REQ-020 Normal latency: done=1 in the 33rd cycle after the edge that accepted start.
REQ-021 Divide by zero (data2=0) SHALL take the DONE path and return:
  - DIV/DIVU: 0xFFFFFFFF.
  - REM/REMU: data1.
REQ-022 Signed overflow (DIV/REM with data1=0x80000000, data2=0xFFFFFFFF) SHALL take the DONE path and return:
  - DIV: 0x80000000.
  - REM: 0x00000000.
REQ-023 Special-case latency SHALL be done=1 in the cycle after acceptance.
REQ-024 A quotient SHALL be negated when the operand signs differ; a remainder SHALL take the dividend's sign.
REQ-025 stall SHALL be combinational: (state==IDLE and start=1 and flush=0) or state==CALC.
REQ-026 stall SHALL be 0 in DONE, so the pipeline advances and captures result on that edge.
REQ-027 After DONE, the next start SHALL be accepted only when presented in IDLE.
  - This allows back-to-back ops with one IDLE cycle between them.
REQ-028 start while in CALC or DONE SHALL be ignored.
REQ-029 flush=1 in any state SHALL force IDLE on the next edge, with no done pulse and the counter cleared.
REQ-030 flush has priority over start.
REQ-031 result SHALL hold its last DONE value until the next DONE; it SHALL be 0 before the first op.
REQ-032 Operand changes after acceptance SHALL NOT affect the result.

Reset
REQ-033 reset=0 SHALL immediately force:
  - state IDLE, counter 0, latched operands 0, accumulators 0, result 0.
  - done 0; stall 0 except for the combinational start term.
REQ-034 reset asserted mid-CALC SHALL abort the op, with no done after reset release.
REQ-035 The first start SHALL be accepted on the first rising edge with reset=1.

Verification
REQ-036 MUL, data1=0xFFFFFFFF (-1), data2=0x00000007 -> done at cycle 33, result 0xFFFFFFF9; stall high cycles 0..32, low at 33.
REQ-037 MULHU, 0xFFFFFFFF × 0xFFFFFFFF -> result 0xFFFFFFFE; MULH of the same operands -> 0x00000000; MULHSU -> 0xFFFFFFFF.
REQ-038 DIV: -7/2 -> 0xFFFFFFFD (-3); REM: -7/2 -> 0xFFFFFFFF (-1); DIVU: 100/7 -> 14; REMU: 100/7 -> 2; each with done at cycle 33.
REQ-039 DIVU x/0 -> 0xFFFFFFFF; REM 0x12345678/0 -> 0x12345678; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; each with done at cycle 1.
REQ-040 flush at cycle 10 of a DIV -> IDLE at cycle 11, no done, result unchanged; a new MUL 3×5 then returns 15 at its cycle 33.
REQ-041 reset=0 at cycle 20 of a MULHU -> stall, done and result read 0 immediately; start held high during CALC is ignored.
